if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_hold_buffer.sv | 43 ++++
 rtl/if_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg : shared types and constants for the instruction fetch unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    REQ_S   = 2'd1,
    WAIT_S  = 2'd2,
    STALL_S = 2'd3
  } fetch_state_t;

  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] C_NOP_INSTR        = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/if_hold_buffer.sv
// ============================================================================
// if_hold_buffer : single-entry instruction/PC register with valid flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_hold_buffer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : single-outstanding instruction fetch stage with a one-entry
//                 hold buffer and flush/redirect support
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] next_pc_in,
  input  logic        flush_in,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        id_ready_in,
  output logic [31:0] pc_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  output logic        id_valid_out,
  output logic [31:0] id_instr_out,
  output logic [31:0] id_pc_out,
  output logic        misalign_out
);

  localparam logic [31:0] C_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic         r_id_valid;
  logic [31:0]  r_id_instr;
  logic [31:0]  r_id_pc;
  logic         r_discard;
  logic         r_misalign;

  logic         w_flush;
  logic         w_slot_free;
  logic         w_pc_load;
  logic         w_id_load;
  logic         w_id_from_buf;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_discard_nxt;
  logic         w_req;

  logic         w_buf_valid;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_pc;

  // Redirects are meaningless while the reset state is still being left
  assign w_flush     = flush_in && (r_state != RESET_S);
  assign w_slot_free = !r_id_valid || id_ready_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_load     = 1'b0;
    w_id_load     = 1'b0;
    w_id_from_buf = 1'b0;
    w_buf_load    = 1'b0;
    w_buf_clear   = 1'b0;
    w_discard_nxt = r_discard;
    w_req         = 1'b0;
    case (r_state)
      RESET_S: begin
        w_state_nxt   = REQ_S;
        w_discard_nxt = 1'b0;
      end
      REQ_S: begin
        w_req = 1'b1;
        if (w_flush) begin
          w_pc_load = 1'b1;
          if (imem_ready_in) begin
            w_state_nxt   = WAIT_S;
            w_discard_nxt = 1'b1;
          end
        end else if (imem_ready_in) begin
          w_state_nxt = WAIT_S;
        end
      end
      WAIT_S: begin
        if (w_flush) begin
          w_pc_load   = 1'b1;
          w_buf_clear = 1'b1;
          if (imem_rvalid_in) begin
            w_state_nxt   = REQ_S;
            w_discard_nxt = 1'b0;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end else if (imem_rvalid_in) begin
          if (r_discard) begin
            // PC was already redirected when the flush arrived
            w_state_nxt   = REQ_S;
            w_discard_nxt = 1'b0;
          end else if (w_slot_free) begin
            w_id_load   = 1'b1;
            w_pc_load   = 1'b1;
            w_state_nxt = REQ_S;
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = STALL_S;
          end
        end
      end
      STALL_S: begin
        if (w_flush) begin
          w_pc_load   = 1'b1;
          w_buf_clear = 1'b1;
          w_state_nxt = REQ_S;
        end else if (id_ready_in) begin
          w_id_from_buf = 1'b1;
          w_pc_load     = 1'b1;
          w_buf_clear   = 1'b1;
          w_state_nxt   = REQ_S;
        end
      end
      default: begin
        w_state_nxt = RESET_S;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= RESET_S;
      r_pc       <= C_RESET_PC_ALIGNED;
      r_discard  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_discard  <= w_discard_nxt;
      r_misalign <= w_pc_load && (next_pc_in[1:0] != 2'b00);
      if (w_pc_load) begin
        r_pc <= {next_pc_in[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (w_flush) begin
      r_id_valid <= 1'b0;
    end else if (w_id_load) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata_in;
      r_id_pc    <= r_pc;
    end else if (w_id_from_buf) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_buf_instr;
      r_id_pc    <= w_buf_pc;
    end else if (id_ready_in) begin
      r_id_valid <= 1'b0;
    end
  end

  if_hold_buffer u_hold_buffer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (imem_rdata_in),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  // The buffer's valid bit is implied by STALL_S; kept for observability
  logic w_unused;
  assign w_unused = w_buf_valid;

  assign pc_out        = r_pc;
  assign imem_req_out  = w_req;
  assign imem_addr_out = r_pc;
  assign id_valid_out  = r_id_valid;
  assign id_instr_out  = r_id_instr;
  assign id_pc_out     = r_id_pc;
  assign misalign_out  = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : directed self-checking bench for if_fetch_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        imem_ready_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = 32'h0;
  logic        id_ready_in = 1'b0;
  logic        use_inc = 1'b0;
  logic [31:0] npc_fixed = 32'h0;
  logic [31:0] next_pc_in;

  logic [31:0] pc_out;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        id_valid_out;
  logic [31:0] id_instr_out;
  logic [31:0] id_pc_out;
  logic        misalign_out;

  int n_checks = 0;
  int n_fail   = 0;

  assign next_pc_in = use_inc ? (pc_out + 32'd4) : npc_fixed;

  always #5 clk_in = ~clk_in;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .next_pc_in     (next_pc_in),
    .flush_in       (flush_in),
    .imem_ready_in  (imem_ready_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .id_ready_in    (id_ready_in),
    .pc_out         (pc_out),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .id_valid_out   (id_valid_out),
    .id_instr_out   (id_instr_out),
    .id_pc_out      (id_pc_out),
    .misalign_out   (misalign_out)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    tick;
    tick;
    n_checks++;
    if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
    n_checks++;
    if ({imem_req_out, id_valid_out, misalign_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got %b exp 000", {imem_req_out, id_valid_out, misalign_out});
    end
    n_checks++;
    if ({id_instr_out, id_pc_out} !== 64'h0) begin
      n_fail++; $display("FAIL reset_id: got %h exp 0", {id_instr_out, id_pc_out});
    end
    rst_in = 1'b0;
    tick;
    n_checks++;
    if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL reset_release_req: got %b/%h exp 1/0", imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_back_to_back;
    use_inc = 1'b1; imem_ready_in = 1'b1; id_ready_in = 1'b1; flush_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_rvalid_in = 1'b0;
      tick;
      n_checks++;
      if ({imem_req_out, id_valid_out} !== 2'b00) begin
        n_fail++; $display("FAIL b2b_wait[%0d]: got %b exp 00", k, {imem_req_out, id_valid_out});
      end
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = 32'hA000_0000 + 32'(k);
      tick;
      n_checks++;
      if ({id_valid_out, id_pc_out, id_instr_out} !== {1'b1, 32'(4 * k), 32'hA000_0000 + 32'(k)}) begin
        n_fail++; $display("FAIL b2b_deliver[%0d]: got %b/%h/%h exp 1/%h/%h", k, id_valid_out,
                           id_pc_out, id_instr_out, 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
      n_checks++;
      if ({imem_req_out, pc_out} !== {1'b1, 32'(4 * k + 4)}) begin
        n_fail++; $display("FAIL b2b_nextpc[%0d]: got %b/%h exp 1/%h", k, imem_req_out, pc_out, 32'(4 * k + 4));
      end
    end
    imem_rvalid_in = 1'b0;
  endtask

  task automatic test_stall;
    imem_ready_in = 1'b0; id_ready_in = 1'b1;
    tick;
    n_checks++;
    if ({id_valid_out, imem_req_out, imem_addr_out} !== {2'b01, 32'h10}) begin
      n_fail++; $display("FAIL stall_drain: got %b/%b/%h exp 0/1/10", id_valid_out, imem_req_out, imem_addr_out);
    end
    imem_ready_in = 1'b1;
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0050_0093;
    tick;
    id_ready_in = 1'b0; imem_rvalid_in = 1'b0;
    tick;
    n_checks++;
    if ({id_valid_out, id_instr_out, id_pc_out} !== {1'b1, 32'h0050_0093, 32'h10}) begin
      n_fail++; $display("FAIL stall_first: got %b/%h/%h exp 1/00500093/10", id_valid_out, id_instr_out, id_pc_out);
    end
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h00A0_0113;
    tick;
    for (int i = 0; i < 3; i++) begin
      imem_rvalid_in = (i == 0);
      imem_rdata_in  = 32'hFFFF_FFFF;
      n_checks++;
      if ({imem_req_out, id_valid_out, id_instr_out, pc_out} !== {2'b01, 32'h0050_0093, 32'h14}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b/%b/%h/%h exp 0/1/00500093/14", i,
                           imem_req_out, id_valid_out, id_instr_out, pc_out);
      end
      tick;
    end
    imem_rvalid_in = 1'b0;
    id_ready_in = 1'b1;
    tick;
    n_checks++;
    if ({id_valid_out, id_instr_out, id_pc_out} !== {1'b1, 32'h00A0_0113, 32'h14}) begin
      n_fail++; $display("FAIL stall_second: got %b/%h/%h exp 1/00a00113/14", id_valid_out, id_instr_out, id_pc_out);
    end
    n_checks++;
    if ({imem_req_out, pc_out} !== {1'b1, 32'h18}) begin
      n_fail++; $display("FAIL stall_resume: got %b/%h exp 1/18", imem_req_out, pc_out);
    end
    imem_ready_in = 1'b0;
    tick;
    n_checks++;
    if (id_valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got %b exp 0", id_valid_out); end
  endtask

  task automatic test_flush_wait;
    imem_ready_in = 1'b1; use_inc = 1'b1;
    tick;
    imem_ready_in = 1'b0; flush_in = 1'b1; use_inc = 1'b0; npc_fixed = 32'h100;
    tick;
    n_checks++;
    if ({imem_req_out, id_valid_out, misalign_out, pc_out} !== {3'b000, 32'h100}) begin
      n_fail++; $display("FAIL flushwait_a: got %b/%b/%b/%h exp 0/0/0/100", imem_req_out, id_valid_out, misalign_out, pc_out);
    end
    flush_in = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF;
    tick;
    imem_rvalid_in = 1'b0;
    n_checks++;
    if ({imem_req_out, id_valid_out, imem_addr_out} !== {2'b10, 32'h100}) begin
      n_fail++; $display("FAIL flushwait_b: got %b/%b/%h exp 1/0/100", imem_req_out, id_valid_out, imem_addr_out);
    end
  endtask

  task automatic test_flush_rvalid;
    imem_ready_in = 1'b1; use_inc = 1'b1;
    tick;
    imem_ready_in = 1'b0; flush_in = 1'b1; use_inc = 1'b0; npc_fixed = 32'h200;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0000_BAD1;
    tick;
    flush_in = 1'b0; imem_rvalid_in = 1'b0;
    n_checks++;
    if ({imem_req_out, id_valid_out, imem_addr_out} !== {2'b10, 32'h200}) begin
      n_fail++; $display("FAIL flush_rvalid: got %b/%b/%h exp 1/0/200", imem_req_out, id_valid_out, imem_addr_out);
    end
  endtask

  task automatic test_flush_handshake;
    imem_ready_in = 1'b1; flush_in = 1'b1; npc_fixed = 32'h300;
    tick;
    n_checks++;
    if ({imem_req_out, pc_out} !== {1'b0, 32'h300}) begin
      n_fail++; $display("FAIL flush_hs_a: got %b/%h exp 0/300", imem_req_out, pc_out);
    end
    flush_in = 1'b0; imem_ready_in = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0000_BAD2;
    tick;
    imem_rvalid_in = 1'b0;
    n_checks++;
    if ({imem_req_out, id_valid_out, imem_addr_out} !== {2'b10, 32'h300}) begin
      n_fail++; $display("FAIL flush_hs_b: got %b/%b/%h exp 1/0/300", imem_req_out, id_valid_out, imem_addr_out);
    end
    flush_in = 1'b1; npc_fixed = 32'h400;
    tick;
    flush_in = 1'b0;
    n_checks++;
    if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h400}) begin
      n_fail++; $display("FAIL flush_req: got %b/%h exp 1/400", imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_misalign;
    flush_in = 1'b1; npc_fixed = 32'h102;
    tick;
    flush_in = 1'b0;
    n_checks++;
    if ({misalign_out, pc_out} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL misalign_pulse: got %b/%h exp 1/100", misalign_out, pc_out);
    end
    tick;
    n_checks++;
    if ({misalign_out, pc_out} !== {1'b0, 32'h100}) begin
      n_fail++; $display("FAIL misalign_clear: got %b/%h exp 0/100", misalign_out, pc_out);
    end
  endtask

  task automatic test_reset_stall;
    use_inc = 1'b1; id_ready_in = 1'b1; imem_ready_in = 1'b1;
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h1111_1111;
    tick;
    id_ready_in = 1'b0; imem_rvalid_in = 1'b0;
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h2222_2222;
    tick;
    imem_rvalid_in = 1'b0;
    n_checks++;
    if ({imem_req_out, id_valid_out, pc_out} !== {2'b01, 32'h104}) begin
      n_fail++; $display("FAIL rststall_pre: got %b/%b/%h exp 0/1/104", imem_req_out, id_valid_out, pc_out);
    end
    rst_in = 1'b1; flush_in = 1'b1; id_ready_in = 1'b1;
    tick;
    n_checks++;
    if ({imem_req_out, id_valid_out, misalign_out, pc_out, id_instr_out, id_pc_out} !== {3'b000, 96'h0}) begin
      n_fail++; $display("FAIL rststall_rst: got %b/%b/%b/%h/%h/%h exp all 0", imem_req_out, id_valid_out,
                         misalign_out, pc_out, id_instr_out, id_pc_out);
    end
    rst_in = 1'b0; flush_in = 1'b0;
    tick;
    n_checks++;
    if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rststall_req: got %b/%h exp 1/0", imem_req_out, imem_addr_out);
    end
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h3333_3333;
    tick;
    imem_rvalid_in = 1'b0;
    n_checks++;
    if ({id_valid_out, id_instr_out, id_pc_out} !== {1'b1, 32'h3333_3333, 32'h0}) begin
      n_fail++; $display("FAIL rststall_fresh: got %b/%h/%h exp 1/33333333/0", id_valid_out, id_instr_out, id_pc_out);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_stall;
    test_flush_wait;
    test_flush_rvalid;
    test_flush_handshake;
    test_misalign;
    test_reset_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
